// File: rtl/sig_sink.sv
// Signature sink: captures signature stores into a first-word-fall-through FIFO
// and sequences end-of-test (RUN -> DRAIN -> HALTED). Optional macro: SIG_SINK_WORD_COUNT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | accepting signature stores, waiting for a halt store
// ST_DRAIN  | halt requested; new stores discarded, FIFO still draining
// ST_HALTED | FIFO empty after halt; halt output follows one edge later
module sig_sink #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] SIG_ADDR  = 32'h00000F00,
    parameter logic [31:0] HALT_ADDR = 32'hCAFEBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic        sig_valid,
    output logic [31:0] sig_data,
    input  logic        sig_ready,
    output logic        halt,
    output logic        overflow,
    output logic [15:0] sig_words
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            halt_q, halt_d;
    logic [31:0]     mem_q [DEPTH];

    logic sig_store, halt_store;
    logic fifo_empty, fifo_full;
    logic push, pop, drop;

    assign sig_store  = !wr && (addr == SIG_ADDR);
    assign halt_store = !wr && (addr == HALT_ADDR);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(DEPTH));

    // A full FIFO still accepts a push when the head word leaves on the same edge.
    assign pop  = !fifo_empty && sig_ready;
    assign push = sig_store && (state_q == ST_RUN) && (!fifo_full || pop);
    assign drop = sig_store && (state_q == ST_RUN) && fifo_full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        halt_d     = halt_q | (state_q == ST_HALTED);
        state_d    = state_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_RUN:    if (halt_store) state_d = ST_DRAIN;
            // Looking at the post-edge occupancy lets the final pop and the exit coincide.
            ST_DRAIN:  if (count_d == '0) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
        end
    end

    // Storage needs no reset: contents are masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_wr;
    end

    assign sig_valid = !fifo_empty;
    assign sig_data  = fifo_empty ? 32'h0 : mem_q[rd_ptr_q];
    assign halt      = halt_q;
    assign overflow  = overflow_q;

`ifdef SIG_SINK_WORD_COUNT_EN
    logic [15:0] words_q, words_d;

    always_comb begin
        words_d = words_q;
        if (push && (words_q != 16'hFFFF)) words_d = words_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) words_q <= 16'h0;
        else      words_q <= words_d;
    end

    assign sig_words = words_q;
`else
    assign sig_words = 16'h0;
`endif

endmodule

// File: doc/sig_sink.md
SIG_SINK -- requirements
Module: sig_sink

Interface
REQ-001 Parameter DEPTH, default 8, signature FIFO depth in words (power of two, 2..64).
REQ-002 Parameter SIG_ADDR, default 32'h00000F00, store address that deposits one signature word.
REQ-003 Parameter HALT_ADDR, default 32'hCAFEBEEF, store address that requests end of test.
REQ-004 Port clk input 1: sole clock, all state updates on rising edge.
REQ-005 Port rst input 1: asynchronous, active-low reset.
REQ-006 Port wr input 1: data-memory write strobe, active-low (0 = store this cycle).
REQ-007 Port addr input 32: memory-stage ALU result (store address).
REQ-008 Port data_wr input 32: store data.
REQ-009 Port sig_valid output 1: sig_data holds an undrained signature word.
REQ-010 Port sig_data output 32: oldest signature word.
REQ-011 Port sig_ready input 1: consumer accepts sig_data this cycle.
REQ-012 Port halt output 1: test finished and all signature words drained.
REQ-013 Port overflow output 1: sticky flag, a signature word was dropped.
REQ-014 Port sig_words output 16: count of signature words accepted into the FIFO.

Function
REQ-015 A sig store is wr==0 && addr==SIG_ADDR; a halt store is wr==0 && addr==HALT_ADDR; all other stores are ignored.
REQ-016 Sig store in RUN pushes data_wr at the rising edge; sig_valid asserts the following cycle (1-cycle latency, first-word-fall-through).
REQ-017 Pop occurs on a rising edge with sig_valid && sig_ready; sig_data advances to the next word in the same edge.
REQ-018 sig_data holds stable while sig_valid && !sig_ready.
REQ-019 Full FIFO with push and no pop: word dropped, overflow set, count unchanged.
REQ-020 Full FIFO with simultaneous push and pop: both occur, occupancy stays DEPTH, no overflow.
REQ-021 Empty FIFO with push: pop is impossible that cycle (sig_valid low); word is stored.
REQ-022 Read/write pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
REQ-023 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-024 RUN -> DRAIN on a halt store; DRAIN -> HALTED on the first edge where the FIFO is empty (including the same edge the last word pops).
REQ-025 Halt store into an empty FIFO: DRAIN lasts exactly one cycle, halt asserts two cycles after the halt store edge.
REQ-026 halt is asserted only in HALTED, registered, and remains set until reset.
REQ-027 Sig stores in DRAIN or HALTED are discarded without setting overflow; repeated halt stores have no effect.
REQ-028 Pops remain permitted in DRAIN; HALTED implies sig_valid==0.

Reset
REQ-029 rst==0 asynchronously forces: FSM RUN, pointers and occupancy 0, sig_valid 0, sig_data 0, halt 0, overflow 0, sig_words 0.
REQ-030 Reset asserted mid-drain or mid-stall discards all buffered words; no word is presented after rst deasserts until a new sig store.
REQ-031 Deassertion is sampled synchronously; first push is accepted on the first rising edge with rst==1.

Configuration
REQ-032 Macro SIG_SINK_WORD_COUNT_EN: when defined, sig_words increments on each accepted push, saturating at 16'hFFFF.
REQ-033 When SIG_SINK_WORD_COUNT_EN is undefined, the counter is not built and sig_words is tied to 0; all other behaviour is identical.

Verification
REQ-034 Three sig stores 11111111, 22222222, 33333333 with sig_ready=1 -> same three words appear in order, each 1 cycle after its store, sig_words=3.
REQ-035 sig_ready=0, DEPTH+1 sig stores of 0..8 -> FIFO holds 0..7, overflow=1, word 8 never appears; then sig_ready=1 drains 0..7.
REQ-036 FIFO full, sig_ready=1, sig store AAAA5555 same cycle -> no overflow, AAAA5555 emerges after the 8 prior words.
REQ-037 Two words buffered, sig_ready=0, halt store -> halt stays 0; raise sig_ready -> both words pop, halt=1 on the edge after the last pop; later sig store 0000DEAD ignored.
REQ-038 Halt store with empty FIFO -> halt=1 exactly 2 cycles later; store to 32'h00000F04 -> no push.
REQ-039 rst=0 pulsed while 4 words buffered in DRAIN -> all outputs 0 immediately, state RUN, sig_valid stays 0 until next sig store.
